// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the CPU trace buffer: FSM states, opcodes and
// record layout helpers. A record is packed {pc, op, addr, data}, with data in the LSBs.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Cycles from an accepted rd_req to rd_valid.
    localparam int RD_LAT = 1;

    function automatic int rec_w(input int aw, input int ow, input int dw);
        return 2*aw + ow + dw;
    endfunction

    function automatic int data_lsb();
        return 0;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int op_lsb(input int aw, input int dw);
        return dw + aw;
    endfunction

    function automatic int pc_lsb(input int aw, input int ow, input int dw);
        return dw + aw + ow;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Simple dual-port record store: synchronous write, registered synchronous read.
// A same-address read and write in one cycle returns the old contents.
module trace_ram #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Only the output register is reset; the array itself holds no valid state.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace buffer for the RISC CPU: one record per executed instruction,
// with opcode trigger, stop-on-full or wrap, and halt-terminated capture.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_valid,
    input  logic [ADDR_W-1:0] cap_pc,
    input  logic [OP_W-1:0]   cap_op,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              halt,
    input  logic              arm,
    input  logic              mode,
    input  logic              trig_en,
    input  logic [OP_W-1:0]   trig_op,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [OP_W-1:0]   rd_op,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              halted,
    output logic [1:0]        state
);

    localparam int REC_W    = rec_w(ADDR_W, OP_W, DATA_W);
    localparam int DATA_LSB = data_lsb();
    localparam int ADDR_LSB = addr_lsb(DATA_W);
    localparam int OP_LSB   = op_lsb(ADDR_W, DATA_W);
    localparam int PC_LSB   = pc_lsb(ADDR_W, OP_W, DATA_W);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] LAST_CNT = (PTR_W+1)'(DEPTH - 1);

    state_t           st_q, st_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovf_q, hlt_q;
    logic [RD_LAT:0]  vld_pipe;
    logic [RD_LAT:1]  vld_q;

    logic             trig_hit, cap_hit, arm_go, full;
    logic             wr_en, do_rd, overwrite;
    logic [REC_W-1:0] wr_rec, rd_rec;

    assign wr_rec   = {cap_pc, cap_op, cap_addr, cap_data};
    assign full     = (cnt_q == FULL_CNT);
    assign trig_hit = !trig_en || (cap_op == trig_op);
    assign arm_go   = arm && (st_q == ST_IDLE || st_q == ST_DONE);
    assign do_rd    = rd_req && (cnt_q != '0);

    // In ARMED only a trigger hit is stored; a full stop-mode buffer never
    // accepts a write unless a pop frees the slot in the same cycle.
    assign cap_hit   = cap_valid && (st_q == ST_CAPTURE || (st_q == ST_ARMED && trig_hit));
    assign wr_en     = cap_hit && !(full && !do_rd && !mode);
    assign overwrite = wr_en && full && !do_rd;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !do_rd && !full)
            cnt_d = cnt_q + 1'b1;
        else if (do_rd && !wr_en)
            cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE, ST_DONE: begin
                if (arm)
                    st_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (wr_en)
                    st_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (halt)
                    st_d = ST_DONE;
                else if (!mode && wr_en && !do_rd && cnt_q == LAST_CNT)
                    st_d = ST_DONE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            st_q <= ST_IDLE;
        else
            st_q <= st_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            hlt_q  <= 1'b0;
        end else if (arm_go) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            hlt_q  <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            // An overwrite discards the oldest record, so the read side moves too.
            if (do_rd || overwrite)
                rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_d;
            if (overwrite)
                ovf_q <= 1'b1;
            if (st_q == ST_CAPTURE && halt)
                hlt_q <= 1'b1;
        end
    end

    assign vld_pipe = {vld_q, do_rd};

    always_ff @(posedge clk) begin
        if (reset)
            vld_q <= '0;
        else
            vld_q <= vld_pipe[RD_LAT-1:0];
    end

    trace_ram #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .re    (do_rd),
        .raddr (rd_ptr),
        .rdata (rd_rec)
    );

    assign rd_valid = vld_pipe[RD_LAT];
    assign rd_data  = rd_rec[DATA_LSB +: DATA_W];
    assign rd_addr  = rd_rec[ADDR_LSB +: ADDR_W];
    assign rd_op    = rd_rec[OP_LSB   +: OP_W];
    assign rd_pc    = rd_rec[PC_LSB   +: ADDR_W];
    assign count    = cnt_q;
    assign overflow = ovf_q;
    assign halted   = hlt_q;
    assign state    = st_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: trigger, stop/wrap, halt, concurrent
// read/write and mid-session reset, with hand-computed expectations.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    logic        clk, reset;
    logic        cap_valid, halt, arm, mode, trig_en, rd_req;
    logic [12:0] cap_pc, cap_addr;
    logic [2:0]  cap_op, trig_op;
    logic [7:0]  cap_data;
    logic        rd_valid, overflow, halted;
    logic [12:0] rd_pc, rd_addr;
    logic [2:0]  rd_op;
    logic [7:0]  rd_data;
    logic [4:0]  count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    cpu_trace_buffer dut (
        .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_op(cap_op), .cap_addr(cap_addr), .cap_data(cap_data), .halt(halt),
        .arm(arm), .mode(mode), .trig_en(trig_en), .trig_op(trig_op),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_op(rd_op),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count),
        .overflow(overflow), .halted(halted), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operand address and data are derived from the pc so reads can be checked fully.
    function automatic logic [12:0] addr_of(input logic [12:0] pc);
        return pc + 13'h100;
    endfunction

    function automatic logic [7:0] data_of(input logic [12:0] pc);
        return pc[7:0] ^ 8'h5A;
    endfunction

    task automatic cap(input logic [12:0] pc, input logic [2:0] op);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_op    = op;
        cap_addr  = addr_of(pc);
        cap_data  = data_of(pc);
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [12:0] pc, input logic [2:0] op);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk({tag, "_vld"},  rd_valid, 1);
        chk({tag, "_pc"},   rd_pc,    pc);
        chk({tag, "_op"},   rd_op,    op);
        chk({tag, "_addr"}, rd_addr,  addr_of(pc));
        chk({tag, "_data"}, rd_data,  data_of(pc));
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cap_valid = 0; halt = 0; arm = 0; mode = 0;
        trig_en = 0; trig_op = 0; rd_req = 0;
        cap_pc = 0; cap_op = 0; cap_addr = 0; cap_data = 0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_vld", rd_valid, 0);
        chk("rst_pc", rd_pc, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_hlt", halted, 0);
        reset = 1'b0;
        tick();

        // Basic capture and in-order drain
        do_arm();
        chk("arm_state", state, 1);
        cap(13'h000, OP_LDA);
        chk("cap1_state", state, 2);
        cap(13'h002, OP_ADD);
        cap(13'h004, OP_STO);
        chk("cap3_count", count, 3);
        chk("cap3_state", state, 2);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_ignored", state, 2);
        pop("r0", 13'h000, OP_LDA);
        tick();
        chk("r0_pulse", rd_valid, 0);
        pop("r1", 13'h002, OP_ADD);
        pop("r2", 13'h004, OP_STO);
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        chk("empty_vld", rd_valid, 0);
        chk("empty_hold", rd_pc, 13'h004);
        chk("empty_count", count, 0);
        halt = 1'b1; tick(); halt = 1'b0;
        chk("halt1_state", state, 3);

        // Opcode trigger on JMP
        trig_en = 1'b1; trig_op = OP_JMP;
        do_arm();
        chk("trg_count0", count, 0);
        chk("trg_hlt_clr", halted, 0);
        cap(13'h010, OP_LDA);
        chk("trg_wait_state", state, 1);
        chk("trg_wait_count", count, 0);
        cap(13'h012, OP_ADD);
        cap(13'h014, OP_JMP);
        chk("trg_hit_state", state, 2);
        cap(13'h016, OP_AND);
        chk("trg_count", count, 2);
        pop("t0", 13'h014, OP_JMP);
        pop("t1", 13'h016, OP_AND);
        halt = 1'b1; tick(); halt = 1'b0;
        trig_en = 1'b0;

        // Stop-on-full
        mode = 1'b0;
        do_arm();
        for (int i = 0; i < 20; i++) cap(13'(2*i), 3'(i));
        chk("stop_count", count, 16);
        chk("stop_state", state, 3);
        chk("stop_ovf", overflow, 0);
        pop("s0", 13'h000, 3'd0);
        chk("stop_count_rd", count, 15);

        // Wrap mode: records 16..19 overwrite 0..3
        mode = 1'b1;
        do_arm();
        for (int i = 0; i < 20; i++) cap(13'(2*i), 3'(i));
        chk("wrap_count", count, 16);
        chk("wrap_ovf", overflow, 1);
        chk("wrap_state", state, 2);
        pop("w0", 13'h008, 3'd4);
        pop("w1", 13'h00A, 3'd5);
        halt = 1'b1; tick(); halt = 1'b0;

        // Halt together with a capture
        mode = 1'b0;
        do_arm();
        cap(13'h040, OP_SKZ);
        cap(13'h042, OP_ADD);
        halt = 1'b1;
        cap(13'h044, OP_HLT);
        halt = 1'b0;
        chk("hlt_state", state, 3);
        chk("hlt_flag", halted, 1);
        chk("hlt_count", count, 3);
        cap(13'h046, OP_XOR);
        chk("hlt_ignore", count, 3);
        pop("h0", 13'h040, OP_SKZ);
        pop("h1", 13'h042, OP_ADD);
        pop("h2", 13'h044, OP_HLT);
        do_arm();
        chk("rearm_state", state, 1);
        chk("rearm_count", count, 0);
        chk("rearm_hlt", halted, 0);

        // Full wrap buffer with concurrent read and write
        mode = 1'b1;
        for (int i = 0; i < 16; i++) cap(13'(13'h200 + 2*i), 3'(i));
        chk("full_count", count, 16);
        chk("full_ovf", overflow, 0);
        rd_req = 1'b1;
        cap(13'h300, OP_STO);
        rd_req = 1'b0;
        chk("rw_vld", rd_valid, 1);
        chk("rw_pc", rd_pc, 13'h200);
        chk("rw_count", count, 16);
        chk("rw_ovf", overflow, 0);
        chk("rw_state", state, 2);
        pop("rw1", 13'h202, 3'd1);
        chk("rw1_count", count, 15);
        cap(13'h302, OP_JMP);
        chk("refill_count", count, 16);
        chk("refill_ovf", overflow, 0);
        cap(13'h304, OP_AND);
        chk("ovw_count", count, 16);
        chk("ovw_ovf", overflow, 1);
        pop("ovw0", 13'h206, 3'd3);

        // Mid-session reset
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mrst_state", state, 0);
        chk("mrst_count", count, 0);
        chk("mrst_vld", rd_valid, 0);
        chk("mrst_pc", rd_pc, 0);
        chk("mrst_op", rd_op, 0);
        chk("mrst_addr", rd_addr, 0);
        chk("mrst_data", rd_data, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_hlt", halted, 0);
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        chk("mrst_rd_empty", rd_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
